// File: rtl/rotary_dial_decoder_pkg.sv
// rotary_pkg: shared quadrature types, dial FSM states and the Gray-step decode helper
package rotary_pkg;
  typedef logic [1:0] quad_t;
  typedef enum logic {INIT, TRACK} dial_state_t;
  // encoding equals the Gray-index difference modulo 4
  typedef enum logic [1:0] {Q_NONE, Q_FWD, Q_ILL, Q_REV} quad_delta_t;
  function automatic quad_delta_t quad_delta(quad_t prev, quad_t cur);
    quad_t ip;
    quad_t ic;
    ip = {prev[1], ^prev};
    ic = {cur[1], ^cur};
    return quad_delta_t'(quad_t'(ic - ip));
  endfunction
endpackage

// File: rtl/rotary_dial_decoder_if.sv
// rotary_dial_decoder_if: encoder pins, clear and PIO-side position signals of one dial
interface rotary_dial_decoder_if #(parameter int WIDTH = 8);
  logic enc_a;
  logic enc_b;
  logic clear;
  logic [WIDTH-1:0] count;
  logic step;
  logic dir;
  logic err;
  modport master(output enc_a, enc_b, clear, input count, step, dir, err);
  modport slave(input enc_a, enc_b, clear, output count, step, dir, err);
endinterface

// File: rtl/dial_debounce.sv
// dial_debounce: 2-FF synchroniser plus shared stability filter for the A/B pair
module dial_debounce
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic  clk,
  input  logic  reset_n,
  input  quad_t ab_raw,
  output quad_t ab_f,
  output logic  valid_f
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  quad_t s1;
  quad_t ab_s;
  quad_t cand;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= '0;
      ab_s    <= '0;
      cand    <= '0;
      cnt     <= '0;
      ab_f    <= '0;
      valid_f <= 1'b0;
    end else begin
      s1      <= ab_raw;
      ab_s    <= s1;
      valid_f <= 1'b0;
      if (ab_s != cand) begin
        cand <= ab_s;
        cnt  <= '0;
      end else if (cnt != CW'(DEBOUNCE_CYCLES)) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          ab_f    <= cand;
          valid_f <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/rotary_dial_decoder.sv
// rotary_dial_decoder: debounced quadrature decode into an 8-bit PIO position count
// Define ROTARY_DIAL_SATURATE_EN to clamp count at its limits instead of wrapping.
module rotary_dial_decoder
  import rotary_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int DETENT_DIV      = 4
) (
  input logic clk,
  input logic reset_n,
  rotary_dial_decoder_if.slave dial
);
  localparam int AW = $clog2(DETENT_DIV + 1) + 1;
  localparam logic signed [AW-1:0] ACC_HI = AW'(DETENT_DIV - 1);
  localparam logic signed [AW-1:0] ACC_LO = -ACC_HI;
`ifdef ROTARY_DIAL_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  quad_t ab_f;
  logic valid_f;
  dial_state_t state, state_n;
  quad_t prev, prev_n;
  quad_delta_t delta;
  logic signed [AW-1:0] acc, acc_n;
  logic [WIDTH-1:0] count, count_n;
  logic step, step_n, dir, dir_n, err, err_n;
  logic up_ok, dn_ok;
  dial_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .ab_raw ({dial.enc_a, dial.enc_b}),
    .ab_f   (ab_f),
    .valid_f(valid_f)
  );
  assign up_ok = !SAT || count != '1;
  assign dn_ok = !SAT || count != '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      prev  <= '0;
      acc   <= '0;
      count <= '0;
      step  <= 1'b0;
      dir   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      prev  <= prev_n;
      acc   <= acc_n;
      count <= count_n;
      step  <= step_n;
      dir   <= dir_n;
      err   <= err_n;
    end
  end
  // the first filtered sample after reset only seeds prev, so a resting dial never counts
  always_comb begin
    state_n = state;
    prev_n  = prev;
    acc_n   = acc;
    count_n = count;
    step_n  = 1'b0;
    dir_n   = dir;
    err_n   = err;
    delta   = quad_delta(prev, ab_f);
    if (valid_f) begin
      prev_n  = ab_f;
      state_n = TRACK;
      if (state == TRACK) begin
        if (delta == Q_ILL) err_n = 1'b1;
        else if (delta == Q_FWD && acc == ACC_HI) begin
          acc_n = '0;
          if (up_ok) begin
            count_n = count + 1'b1;
            dir_n   = 1'b1;
            step_n  = 1'b1;
          end
        end else if (delta == Q_REV && acc == ACC_LO) begin
          acc_n = '0;
          if (dn_ok) begin
            count_n = count - 1'b1;
            dir_n   = 1'b0;
            step_n  = 1'b1;
          end
        end else if (delta == Q_FWD) acc_n = acc + AW'(1);
        else if (delta == Q_REV) acc_n = acc - AW'(1);
      end
    end
    if (dial.clear) begin
      count_n = '0;
      acc_n   = '0;
      err_n   = 1'b0;
      step_n  = 1'b0;
    end
  end
  assign dial.count = count;
  assign dial.step  = step;
  assign dial.dir   = dir;
  assign dial.err   = err;
endmodule

// File: tb/tb_rotary_dial_decoder.sv
// tb_rotary_dial_decoder: directed detent, wrap, bounce, illegal-jump and clear checks
module tb_rotary_dial_decoder;
`ifdef ROTARY_DIAL_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int steps = 0;
  int exp_steps = 0;
  int pos = 0;
  logic [7:0] exp_count = 8'h00;
  logic exp_dir = 1'b0;
  logic seen;

  rotary_dial_decoder_if #(.WIDTH(8)) dif ();

  rotary_dial_decoder #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .DETENT_DIV(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .dial   (dif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dif.step) steps++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] gray(input int i);
    case (i & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic put(input logic [1:0] ab, input int n);
    dif.enc_a = ab[1];
    dif.enc_b = ab[0];
    repeat (n) @(negedge clk);
  endtask

  task automatic detent(input bit up, input string tag);
    for (int k = 0; k < 4; k++) begin
      pos = up ? pos + 1 : pos - 1;
      put(gray(pos), 10);
    end
    if (up ? (!SAT || exp_count != 8'hff) : (!SAT || exp_count != 8'h00)) begin
      exp_count = up ? exp_count + 8'd1 : exp_count - 8'd1;
      exp_dir   = up;
      exp_steps++;
    end
    check({tag, "_count"}, 32'(dif.count), 32'(exp_count));
    check({tag, "_dir"}, 32'(dif.dir), 32'(exp_dir));
    check({tag, "_steps"}, steps, exp_steps);
  endtask

  initial begin
    dif.enc_a = 1'b1;
    dif.enc_b = 1'b1;
    dif.clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(dif.count), 0);
    check("rst_step", 32'(dif.step), 0);
    check("rst_dir", 32'(dif.dir), 0);
    check("rst_err", 32'(dif.err), 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rest11_state", 32'(dut.state), 1);
    check("rest11_count", 32'(dif.count), 0);
    check("rest11_err", 32'(dif.err), 0);
    check("rest11_steps", steps, 0);
    reset_n = 1'b0;
    put(2'b00, 3);
    reset_n = 1'b1;
    pos = 0;
    repeat (20) @(negedge clk);
    check("rest00_state", 32'(dut.state), 1);
    detent(1'b1, "fwd1");
    for (int i = 0; i < 4; i++) detent(1'b0, $sformatf("rev%0d", i + 1));
    for (int i = 0; i < 20; i++) begin
      dif.enc_a = ~dif.enc_a;
      repeat (2) @(negedge clk);
    end
    put(2'b00, 10);
    check("bounce_count", 32'(dif.count), 32'(exp_count));
    check("bounce_err", 32'(dif.err), 0);
    check("bounce_steps", steps, exp_steps);
    detent(1'b1, "post_bounce");
    pos = pos + 2;
    put(gray(pos), 10);
    check("jump_err", 32'(dif.err), 1);
    check("jump_count", 32'(dif.count), 32'(exp_count));
    check("jump_steps", steps, exp_steps);
    for (int k = 0; k < 3; k++) begin
      pos++;
      put(gray(pos), 10);
    end
    pos++;
    dif.enc_a = gray(pos) >> 1;
    dif.enc_b = gray(pos) & 2'b01;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = dut.valid_f;
    end
    check("clr_valid_seen", 32'(seen), 1);
    dif.clear = 1'b1;
    @(negedge clk);
    dif.clear = 1'b0;
    check("clr_count", 32'(dif.count), 0);
    check("clr_err", 32'(dif.err), 0);
    check("clr_step", 32'(dif.step), 0);
    check("clr_steps", steps, exp_steps);
    exp_count = 8'h00;
    repeat (10) @(negedge clk);
    detent(1'b0, "wrap_dn");
    detent(1'b1, "wrap_up");
    pos++;
    put(gray(pos), 10);
    pos++;
    put(gray(pos), 10);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_count", 32'(dif.count), 0);
    check("midrst_dir", 32'(dif.dir), 0);
    exp_count = 8'h00;
    exp_dir = 1'b0;
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    detent(1'b1, "after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
